// File: rtl/demod_byte_tx.sv
// Sample FIFO plus MSB/LSB byte serialiser feeding a UART transmitter.
// Define DEMOD_HDR_EN to prefix every FRAME_LEN samples with an A5 5A header.
module demod_byte_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   data_i,
    input  logic                          valid_i,
    output logic [7:0]                    byte_o,
    output logic                          byte_valid_o,
    input  logic                          byte_ready_i,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
`ifdef DEMOD_HDR_EN
        HDR0,
        HDR1,
`endif
        MSB,
        LSB
    } state_t;

    state_t        state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [15:0]   sample_q;
    logic          nonempty_q;

    logic          pop;
    logic          push;
    logic          full;
    logic          more;
    logic [15:0]   head;
    logic [15:0]   next_sample;

    assign pop  = byte_valid_o && byte_ready_i && (state == LSB);
    assign full = (count == CW'(FIFO_DEPTH));
    assign push = valid_i && (!full || pop);
    assign head = mem[rptr];
    // A sample pushed on the popping edge is forwarded so streaming never stalls.
    assign more        = (count > CW'(1)) || push;
    assign next_sample = (count > CW'(1)) ? mem[rptr + AW'(1)] : data_i;
    assign fifo_count_o = count;

`ifdef DEMOD_HDR_EN
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [FC_W-1:0] frame_cnt;
    logic            frame_wrap;
    logic            hdr_start;

    assign frame_wrap = (frame_cnt == FC_W'(FRAME_LEN - 1));
    assign hdr_start  = (state == LSB) ? frame_wrap : (frame_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (pop) begin
            frame_cnt <= frame_wrap ? '0 : frame_cnt + FC_W'(1);
        end
    end
`else
    localparam int unused_frame_len = FRAME_LEN;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            nonempty_q <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (valid_i && full && !pop) begin
                overflow_o <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // IDLE starts one cycle after the head settles in storage.
            nonempty_q <= (count != '0) && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            byte_o       <= 8'h00;
            byte_valid_o <= 1'b0;
            sample_q     <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (nonempty_q) begin
                        sample_q     <= head;
                        byte_valid_o <= 1'b1;
`ifdef DEMOD_HDR_EN
                        if (hdr_start) begin
                            state  <= HDR0;
                            byte_o <= 8'hA5;
                        end else
`endif
                        begin
                            state  <= MSB;
                            byte_o <= head[15:8];
                        end
                    end
                end
`ifdef DEMOD_HDR_EN
                HDR0: begin
                    if (byte_ready_i) begin
                        state  <= HDR1;
                        byte_o <= 8'h5A;
                    end
                end
                HDR1: begin
                    if (byte_ready_i) begin
                        state  <= MSB;
                        byte_o <= sample_q[15:8];
                    end
                end
`endif
                MSB: begin
                    if (byte_ready_i) begin
                        state  <= LSB;
                        byte_o <= sample_q[7:0];
                    end
                end
                LSB: begin
                    if (byte_ready_i) begin
                        if (more) begin
                            sample_q <= next_sample;
`ifdef DEMOD_HDR_EN
                            if (hdr_start) begin
                                state  <= HDR0;
                                byte_o <= 8'hA5;
                            end else
`endif
                            begin
                                state  <= MSB;
                                byte_o <= next_sample[15:8];
                            end
                        end else begin
                            state        <= IDLE;
                            byte_valid_o <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
